// File: rtl/ctrl_packet_decoder.sv
// Control packet FIFO + one-stage registered decoder feeding the unit array dispatcher.
// Malformed packets are dropped with saturating error accounting.
module ctrl_packet_decoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ERR_CNT_W  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [29:0]                           in_pkt,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [28:0]                           out_ctrl,
  input  logic                                  flush,
  input  logic                                  err_clr,
  output logic                                  err_sticky,
  output logic [ERR_CNT_W-1:0]                  err_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PKT_W = 30;
  localparam int unsigned OUT_W = 29;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_COPY    = 3'd3;
  localparam logic [2:0] OP_ADD_VEC = 3'd4;

  logic [PKT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_ctrl;
  logic             r_err_sticky;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [PKT_W-1:0] w_head;
  logic [7:0]       w_unit;
  logic [7:0]       w_src;
  logic [2:0]       w_op;
  logic [1:0]       w_comp;
  logic [3:0]       w_addr;
  logic [2:0]       w_size;
  logic             w_illegal;
  logic             w_selfref;
  logic             w_keep;
  logic             w_err_drop;
  logic [OUT_W-1:0] w_decoded;
  logic             w_unused;

  assign w_full   = (r_level == LVL_W'(FIFO_DEPTH));
  assign in_ready = !w_full && !flush && !rst;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_level != '0) && (!r_out_valid || out_ready) && !flush;

  // Head-of-FIFO field extraction; ctrl[0] and config[3] are don't-care.
  assign w_head   = r_mem[r_rd_ptr];
  assign w_unit   = w_head[29:22];
  assign w_src    = w_head[21:14];
  assign w_op     = w_head[13:11];
  assign w_comp   = w_head[10:9];
  assign w_addr   = w_head[7:4];
  assign w_size   = w_head[2:0];
  assign w_unused = ^{w_head[8], w_head[3]};

  assign w_illegal  = (w_op[2:1] == 2'b11);
  assign w_selfref  = ((w_op == OP_COPY) || (w_op == OP_ADD_VEC)) && (w_src == w_unit);
  assign w_err_drop = w_pop && (w_illegal || w_selfref);
  assign w_keep     = w_pop && (w_op != OP_NOP) && !w_illegal && !w_selfref;
  assign w_decoded  = {w_unit, w_src, w_op, w_comp, w_addr, w_size, 1'b1};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_pkt;
  end

  // Pointers and exact occupancy; flush and reset both empty the FIFO.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Output register: a pop always replaces the slot, dropped packets leave it empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= w_keep;
      if (w_keep) r_out_ctrl <= w_decoded;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Clear wins over history but not over an error dropped in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end else if (err_clr) begin
      r_err_sticky <= w_err_drop;
      r_err_count  <= ERR_CNT_W'(w_err_drop);
    end else if (w_err_drop) begin
      r_err_sticky <= 1'b1;
      if (r_err_count != '1) r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_ctrl   = r_out_ctrl;
  assign err_sticky = r_err_sticky;
  assign err_count  = r_err_count;
  assign fifo_level = r_level;

endmodule

// File: doc/ctrl_packet_decoder.md
# ctrl_packet_decoder

Buffers incoming `accel_pkg::ctrl_packet_t` control packets and decodes them into `accel_pkg::decoded_ctrl_t` commands for the unit array dispatcher. It sits between the host command interface and the per-unit dispatch logic, with valid/ready handshakes on both sides. Internally it has a small packet FIFO, a one-stage registered decoder, and error accounting for malformed packets.

## Interface
- `FIFO_DEPTH`, default 4: input packet FIFO entries, power of two, ≥2.
- `ERR_CNT_W`, default 16: width of the saturating error counter.
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: reset is synchronous and active-high.
- `in_valid` in 1: upstream packet valid.
- `in_ready` out 1: `!fifo_full && !flush`.
- `in_pkt` in 30: `ctrl_packet_t`, fields unit_id[29:22], src_unit_id[21:14], ctrl[13:8], config[7:0].
- `out_valid` out 1: decoded command valid.
- `out_ready` in 1: downstream accepts.
- `out_ctrl` out 29: `decoded_ctrl_t`.
- `flush` in 1: drops all buffered and registered packets.
- `err_clr` in 1: clears the error counter and the sticky flag.
- `err_sticky` out 1: set on any dropped malformed packet.
- `err_count` out ERR_CNT_W: malformed packets dropped, saturating.
- `fifo_level` out $clog2(FIFO_DEPTH+1): current FIFO occupancy.

## Operation
- Accept: `in_valid && in_ready` writes `in_pkt` at the FIFO tail.
- Pop: FIFO head is popped when the FIFO is non-empty and the output register is free. The register is free when `!out_valid || out_ready`.
- Decode field map:
  - op_code = ctrl[5:3]
  - comp_type = ctrl[2:1]
  - addr = config[7:4]
  - size = config[2:0]
  - unit_id and src_unit_id copied unchanged
  - valid = 1
  - ctrl[0] and config[3] ignored
- Drop rules: a popped packet is consumed and nothing is registered (out_valid goes or stays 0 unless refilled) when any of these hold:
  - op_code = OP_NOP: silent drop, not an error.
  - op_code ∈ {3'b110, 3'b111}: illegal, counted as an error.
  - op_code = OP_COPY or OP_ADD_VEC with src_unit_id == unit_id: self-reference, counted as an error.
- comp_type is passed through for every op. Downstream uses it only for OP_COMPUTE.
- Errors: each error drop sets `err_sticky` and increments `err_count`. The counter saturates at all-ones.
- `err_clr`: clears the counter and the flag. If `err_clr` and an error drop occur in the same cycle, the result is count = 1, sticky = 1.
- `flush`: at the next edge, FIFO pointers reset, level = 0, out_valid = 0. A packet offered in the flush cycle is not accepted (in_ready = 0). Error state is unaffected.
- Order: decoded commands leave in arrival order. There is no reordering and no duplication.

## Timing
- Reset values: in_ready = 0 during the cycle `rst` is high, 1 afterwards. out_valid = 0, out_ctrl = 0, err_sticky = 0, err_count = 0, fifo_level = 0.
- Latency: a packet accepted at edge N is popped in cycle N+1 and appears with out_valid = 1 in cycle N+2. Minimum latency is 2 cycles.
- Throughput: 1 packet/cycle with out_ready held high. Each dropped packet consumes one pop slot.
- Backpressure: while `out_valid && !out_ready`, out_ctrl is held stable and no pop occurs. The FIFO absorbs FIFO_DEPTH packets, then in_ready falls.
- Simultaneous push and pop when full:
  - There is no push, since in_ready = 0 while full.
  - The pop frees a slot, so in_ready = 1 in the following cycle.
- Simultaneous push and pop when empty: no bypass. The pushed packet pops next cycle.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is exact for every push/pop combination.
- `rst` during active traffic: everything returns to its reset values at that edge, and in-flight packets are lost.

## Test plan
- Single OP_LOAD: in_pkt unit_id = 8'h05, src = 8'h00, ctrl = 6'b001_00_0, config = 8'h3_2 (addr 3, size 2), accepted at cycle 1 → out_valid in cycle 3 with op = OP_LOAD, addr = 3, size = 2, unit_id = 5, valid = 1; err_count = 0.
- Backpressure/full: out_ready = 0, push 6 packets → 1 registered, 4 in the FIFO, in_ready = 0 with fifo_level = 4. Release out_ready → all 5 emitted in order at 1/cycle, after which the 6th is accepted.
- Drops: stream NOP, opcode 3'b111, OP_COPY with src = dst = 8'h10, then OP_ADD_VEC with src 8'h01/dst 8'h02 → only the ADD_VEC is emitted; err_count = 2, err_sticky = 1.
- Saturation and clear: drive 2^ERR_CNT_W + 3 illegal packets → err_count = all-ones. Assert err_clr in the same cycle as an error drop → count = 1, sticky = 1.
- Flush: with 3 buffered packets and out_valid high, pulse flush while in_valid = 1 → next cycle out_valid = 0 and fifo_level = 0, and the offered packet is not accepted.
- Reset mid-stream: assert rst with FIFO at level 2 → all outputs at reset values next cycle; a packet pushed after reset emerges alone.
